// File: rtl/soin_bp_pkg.sv
// Shared definitions for the gshare predictor: meta field layout, counter
// constants, saturating counter arithmetic and FSM encodings.
package soin_bp_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bp_state_e;

  // Meta layout is {ghr_snap, index, ctr}, ctr in the low bits.
  function automatic int meta_ctr_lsb();
    return 0;
  endfunction

  function automatic int meta_idx_lsb(input int ctr_bits);
    return ctr_bits;
  endfunction

  function automatic int meta_ghr_lsb(input int idx_bits, input int ctr_bits);
    return idx_bits + ctr_bits;
  endfunction

  // Weakly not-taken value (01 for a 2-bit counter).
  function automatic int ctr_weak_nt(input int ctr_bits);
    return (1 << (ctr_bits - 1)) - 1;
  endfunction

  function automatic int ctr_sat_step(input int ctr, input logic up, input int ctr_bits);
    int top;
    top = (1 << ctr_bits) - 1;
    if (up) return (ctr >= top) ? top : ctr + 1;
    return (ctr <= 0) ? 0 : ctr - 1;
  endfunction

endpackage

// File: rtl/soin_bp_pht.sv
// 1R1W synchronous-read pattern history table; a read that hits the address
// being written in the same cycle returns the incoming data.
module soin_bp_pht #(
  parameter int AW = 12,
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/soin_gshare_pht_predictor.sv
// Gshare direction predictor with speculative global history, checkpoint
// recovery from execute, post-reset PHT initialisation sweep and in-block counter update.
module soin_gshare_pht_predictor
  import soin_bp_pkg::*;
#(
  parameter int GHR_BITS = 12,
  parameter int IDX_BITS = 12,
  parameter int CTR_BITS = 2,
  parameter int META_W   = GHR_BITS + IDX_BITS + CTR_BITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_stall,
  input  logic [31:0]       fetch_PC,
  input  logic              fetch_is_cond,
  output logic              bp_ready,
  output logic              bp_p_dir,
  output logic [META_W-1:0] bp_meta,
  input  logic              exe_update,
  input  logic              exe_dir,
  input  logic              exe_miss,
  input  logic [META_W-1:0] exe_meta
);

  localparam int L_CTR_LSB = meta_ctr_lsb();
  localparam int L_IDX_LSB = meta_idx_lsb(CTR_BITS);
  localparam int L_GHR_LSB = meta_ghr_lsb(IDX_BITS, CTR_BITS);
  localparam logic [CTR_BITS-1:0] L_WEAK_NT  = CTR_BITS'(ctr_weak_nt(CTR_BITS));
  localparam logic [IDX_BITS-1:0] L_LAST_IDX = '1;

  bp_state_e           r_state;
  logic [IDX_BITS-1:0] r_init_idx;
  logic [GHR_BITS-1:0] r_ghr_spec;
  logic                r_wr_vld;
  logic [IDX_BITS-1:0] r_wr_idx;
  logic [CTR_BITS-1:0] r_wr_ctr;
  logic [IDX_BITS-1:0] r_idx;
  logic [GHR_BITS-1:0] r_snap;

  logic                w_ready;
  logic [IDX_BITS-1:0] w_idx;
  logic [GHR_BITS-1:0] w_exe_ghr;
  logic [IDX_BITS-1:0] w_exe_idx;
  logic [CTR_BITS-1:0] w_exe_ctr;
  logic [CTR_BITS-1:0] w_ctr_new;
  logic [CTR_BITS-1:0] w_ctr;
  logic                w_we;
  logic [IDX_BITS-1:0] w_waddr;
  logic [CTR_BITS-1:0] w_wdata;
  logic                w_unused;

  assign w_ready   = (r_state == ST_RUN);
  assign w_idx     = r_ghr_spec[IDX_BITS-1:0] ^ fetch_PC[IDX_BITS+1:2];
  assign w_exe_ghr = exe_meta[L_GHR_LSB +: GHR_BITS];
  assign w_exe_idx = exe_meta[L_IDX_LSB +: IDX_BITS];
  assign w_exe_ctr = exe_meta[L_CTR_LSB +: CTR_BITS];
  assign w_ctr_new = CTR_BITS'(ctr_sat_step(int'(w_exe_ctr), exe_dir, CTR_BITS));
  assign w_unused  = ^{fetch_PC[31:IDX_BITS+2], fetch_PC[1:0], w_exe_ghr[GHR_BITS-1]};

  // The init sweep owns the write port until the last index is written.
  always_comb begin
    w_we    = r_wr_vld;
    w_waddr = r_wr_idx;
    w_wdata = r_wr_ctr;
    if (r_state == ST_INIT) begin
      w_we    = 1'b1;
      w_waddr = r_init_idx;
      w_wdata = L_WEAK_NT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_init_idx <= '0;
      r_ghr_spec <= '0;
      r_wr_vld   <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_wr_vld <= 1'b0;
          if (r_init_idx == L_LAST_IDX) r_state <= ST_RUN;
          else                          r_init_idx <= r_init_idx + IDX_BITS'(1);
        end
        ST_RUN: begin
          r_wr_vld <= exe_update;
          // Recovery restores the checkpoint plus the real outcome and wins over a fetch shift.
          if (exe_update && exe_miss)
            r_ghr_spec <= {w_exe_ghr[GHR_BITS-2:0], exe_dir};
          else if (fetch_is_cond && !fetch_stall)
            r_ghr_spec <= {r_ghr_spec[GHR_BITS-2:0], bp_p_dir};
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (exe_update) begin
      r_wr_idx <= w_exe_idx;
      r_wr_ctr <= w_ctr_new;
    end
    if (!fetch_stall) begin
      r_idx  <= w_idx;
      r_snap <= r_ghr_spec;
    end
  end

  soin_bp_pht #(
    .AW (IDX_BITS),
    .DW (CTR_BITS)
  ) u_pht (
    .clk     (clk),
    .i_re    (!fetch_stall),
    .i_raddr (w_idx),
    .o_rdata (w_ctr),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata)
  );

  assign bp_ready = w_ready;
  assign bp_p_dir = w_ready & w_ctr[CTR_BITS-1];
  assign bp_meta  = w_ready ? {r_snap, r_idx, w_ctr} : '0;

endmodule

// File: tb/tb_soin_gshare_pht_predictor.sv
// Directed bench for the gshare predictor: init sweep, training, speculation,
// recovery, bypass and mid-sweep reset.
module tb_soin_gshare_pht_predictor;

  localparam int META_W = 26;

  logic              clk;
  logic              reset;
  logic              fetch_stall;
  logic [31:0]       fetch_PC;
  logic              fetch_is_cond;
  logic              bp_ready;
  logic              bp_p_dir;
  logic [META_W-1:0] bp_meta;
  logic              exe_update;
  logic              exe_dir;
  logic              exe_miss;
  logic [META_W-1:0] exe_meta;

  int total;
  int bad;

  typedef struct packed {
    logic [31:0]       pc;
    logic              dir;
    logic [META_W-1:0] meta;
  } vec_t;

  vec_t vecs [4];

  soin_gshare_pht_predictor dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_stall   (fetch_stall),
    .fetch_PC      (fetch_PC),
    .fetch_is_cond (fetch_is_cond),
    .bp_ready      (bp_ready),
    .bp_p_dir      (bp_p_dir),
    .bp_meta       (bp_meta),
    .exe_update    (exe_update),
    .exe_dir       (exe_dir),
    .exe_miss      (exe_miss),
    .exe_meta      (exe_meta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [META_W-1:0] mk(input logic [11:0] g, input logic [11:0] i,
                                           input logic [1:0] c);
    return {g, i, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_resp(input string name, input logic dir, input logic [META_W-1:0] meta);
    check({name, ".dir"}, 32'(bp_p_dir), 32'(dir));
    check({name, ".meta"}, 32'(bp_meta), 32'(meta));
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!bp_ready && n < 6000) begin
      tick();
      n++;
    end
    check(name, 32'(n), 32'd4096);
  endtask

  task automatic update(input logic dir, input logic miss, input logic [META_W-1:0] meta);
    exe_update = 1'b1;
    exe_dir    = dir;
    exe_miss   = miss;
    exe_meta   = meta;
  endtask

  task automatic no_update();
    exe_update = 1'b0;
    exe_dir    = 1'b0;
    exe_miss   = 1'b0;
    exe_meta   = '0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{32'h0000_0100, 1'b0, {12'h000, 12'h040, 2'b01}};
    vecs[1] = '{32'h0000_3FFC, 1'b0, {12'h000, 12'hFFF, 2'b01}};
    vecs[2] = '{32'hFFFF_0004, 1'b0, {12'h000, 12'h001, 2'b01}};
    vecs[3] = '{32'h0000_2BC0, 1'b0, {12'h000, 12'hAF0, 2'b01}};

    reset = 1'b1; fetch_stall = 1'b0; fetch_PC = '0; fetch_is_cond = 1'b0;
    no_update();
    tick();
    check("rst.ready", 32'(bp_ready), 32'd0);
    check_resp("rst", 1'b0, '0);
    reset = 1'b0;
    wait_ready("init.cycles");

    for (int k = 0; k < 4; k++) begin
      fetch_PC = vecs[k].pc;
      tick();
      check_resp($sformatf("vec%0d", k), vecs[k].dir, vecs[k].meta);
    end

    // Training at index 0x040; the lookup in the update cycle still sees the old counter.
    fetch_PC = 32'h100;
    update(1'b1, 1'b0, mk(12'h000, 12'h040, 2'b01));
    tick();
    check_resp("train.same", 1'b0, mk(12'h000, 12'h040, 2'b01));
    no_update();
    tick();
    check_resp("train.1", 1'b1, mk(12'h000, 12'h040, 2'b10));
    update(1'b1, 1'b0, mk(12'h000, 12'h040, 2'b10));
    tick();
    no_update();
    tick();
    check_resp("train.2", 1'b1, mk(12'h000, 12'h040, 2'b11));
    update(1'b1, 1'b0, mk(12'h000, 12'h040, 2'b11));
    tick();
    no_update();
    tick();
    check_resp("train.sat_hi", 1'b1, mk(12'h000, 12'h040, 2'b11));

    update(1'b0, 1'b0, mk(12'h000, 12'h555, 2'b01));
    tick();
    update(1'b0, 1'b0, mk(12'h000, 12'h555, 2'b00));
    tick();
    no_update();
    fetch_PC = 32'h1554;
    tick();
    check_resp("train.sat_lo", 1'b0, mk(12'h000, 12'h555, 2'b00));

    // Bypass: lookup of 0x2F0 lands in the write cycle.
    fetch_PC = 32'h100;
    update(1'b1, 1'b0, mk(12'h000, 12'h2F0, 2'b01));
    tick();
    no_update();
    fetch_PC = 32'hBC0;
    tick();
    check_resp("bypass", 1'b1, mk(12'h000, 12'h2F0, 2'b10));
    fetch_PC = 32'h100;
    tick();
    fetch_PC = 32'hBC0;
    tick();
    check_resp("bypass.stored", 1'b1, mk(12'h000, 12'h2F0, 2'b10));

    // Speculative history: responses 1,0,1 shift in to give 0x005.
    fetch_PC = 32'h100;
    tick();
    check_resp("spec.s0", 1'b1, mk(12'h000, 12'h040, 2'b11));
    fetch_is_cond = 1'b1;
    fetch_PC = 32'h1000;
    tick();
    check_resp("spec.s1", 1'b0, mk(12'h000, 12'h400, 2'b01));
    fetch_PC = 32'h104;
    tick();
    check_resp("spec.s2", 1'b1, mk(12'h001, 12'h040, 2'b11));
    fetch_PC = 32'h100;
    tick();
    check_resp("spec.s3", 1'b0, mk(12'h002, 12'h042, 2'b01));
    fetch_stall = 1'b1;
    fetch_PC = 32'h200;
    tick();
    check_resp("stall.1", 1'b0, mk(12'h002, 12'h042, 2'b01));
    tick();
    check_resp("stall.2", 1'b0, mk(12'h002, 12'h042, 2'b01));
    fetch_stall = 1'b0;
    fetch_is_cond = 1'b0;
    fetch_PC = 32'h0;
    tick();
    check_resp("spec.ghr", 1'b0, mk(12'h005, 12'h005, 2'b01));

    // Recovery beats a same-cycle fetch shift.
    update(1'b0, 1'b1, mk(12'h0A3, 12'h123, 2'b10));
    fetch_is_cond = 1'b1;
    tick();
    no_update();
    fetch_is_cond = 1'b0;
    tick();
    check_resp("recover", 1'b0, mk(12'h146, 12'h146, 2'b01));

    update(1'b1, 1'b1, mk(12'hFFF, 12'h123, 2'b01));
    tick();
    no_update();
    tick();
    check_resp("recover.wrap", 1'b0, mk(12'hFFF, 12'hFFF, 2'b01));
    fetch_is_cond = 1'b1;
    tick();
    fetch_is_cond = 1'b0;
    tick();
    check_resp("shift.wrap", 1'b0, mk(12'hFFE, 12'hFFE, 2'b01));

    // Mid-sweep reset; execute traffic during the sweep must be ignored.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 1000; k++) tick();
    check("mid.ready", 32'(bp_ready), 32'd0);
    reset = 1'b1;
    tick();
    check("mid.rst.ready", 32'(bp_ready), 32'd0);
    check_resp("mid.rst", 1'b0, '0);
    reset = 1'b0;
    fetch_PC = 32'h100;
    fetch_is_cond = 1'b1;
    update(1'b1, 1'b1, mk(12'h0A3, 12'h040, 2'b10));
    wait_ready("mid.cycles");
    check_resp("mid.first", 1'b0, mk(12'h000, 12'h040, 2'b01));
    no_update();
    fetch_is_cond = 1'b0;
    tick();
    check_resp("mid.reinit", 1'b0, mk(12'h000, 12'h040, 2'b01));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/soin_gshare_pht_predictor.md
Name: soin_gshare_pht_predictor

Overview:
- Parametrised gshare direction predictor: the next generation of the fixed 12-bit GHR/PHT bimodal-gshare block.
- New over the previous block:
  - saturating counter arithmetic is done inside the block; execute supplies only outcome plus meta;
  - speculative global history with checkpoint recovery on mispredict;
  - PHT initialisation sweep after reset;
  - write-to-read bypass.
- Sits beside fetch. Returns direction and meta one cycle after the fetch PC. Execute returns the meta at resolution.

Parameters:
- GHR_BITS, 12, global history length
- IDX_BITS, 12, PHT index width (PHT depth = 2^IDX_BITS); requires IDX_BITS <= GHR_BITS
- CTR_BITS, 2, saturating counter width
- META_W, GHR_BITS+IDX_BITS+CTR_BITS, derived; meta = {ghr_snap, index, ctr}

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- fetch_stall  in  1  hold lookup pipeline and speculative GHR
- fetch_PC  in  32  PC to look up (sampled at edge)
- fetch_is_cond  in  1  instruction returned this cycle is a conditional branch
- bp_ready  out  1  initialisation complete
- bp_p_dir  out  1  predicted taken (counter MSB)
- bp_meta  out  META_W  checkpoint for the looked-up branch
- exe_update  in  1  resolved conditional branch
- exe_dir  in  1  actual direction
- exe_miss  in  1  direction mispredicted
- exe_meta  in  META_W  meta returned from fetch

Behaviour:
- Index: idx = ghr_spec[IDX_BITS-1:0] ^ fetch_PC[IDX_BITS+1:2], computed combinationally. PHT uses synchronous read.
- Response latency is 1 cycle:
  - bp_p_dir = ctr[CTR_BITS-1];
  - bp_meta = {ghr_spec as sampled with PC, idx_r, ctr}.
- fetch_stall=1:
  - PHT address, idx_r and the response registers hold;
  - outputs stay stable;
  - GHR does not shift.
- Speculative GHR:
  - fetch_is_cond & ~fetch_stall & bp_ready -> ghr_spec <= {ghr_spec[GHR_BITS-2:0], bp_p_dir}.
  - exe_update & exe_miss -> ghr_spec <= {meta.ghr_snap[GHR_BITS-2:0], exe_dir}.
  - Recovery has priority over a same-cycle fetch shift.
- Counter update:
  - on exe_update, new = ctr + 1 saturating at 2^CTR_BITS-1 if exe_dir, else ctr - 1 saturating at 0;
  - ctr comes from exe_meta;
  - PHT is written at meta.index in the next cycle (registered write, 1-cycle write latency).
- Bypass: if a lookup read address equals the write address in the write cycle, the response returns the new value, not the stale array data.
- FSM states:
  - INIT: counter init_idx sweeps 0..2^IDX_BITS-1, writing 2^(CTR_BITS-1)-1 (weakly not-taken, 01 for 2 bits). bp_ready=0, bp_p_dir=0, exe_update ignored, GHR held at 0. Transitions to RUN after the last index is written.
  - RUN: normal operation. bp_ready=1.
- Reset, including mid-operation: state=INIT, init_idx=0, ghr_spec=0, bp_p_dir=0, bp_meta=0, pending write cleared.
- Wrap-around: GHR shifts discard the MSB. init_idx terminal compare is done at full width, with no overflow past the depth.
- Simultaneous exe_update to index X and lookup to X: the lookup sees the old value. The bypass applies only in the write cycle.

Decomposition:
- Shared package/header soin_bp_pkg:
  - META field offsets (GHR/IDX/CTR slices);
  - CTR_WEAK_NT constant;
  - saturating increment/decrement function;
  - FSM state encodings.
- One sub-module soin_bp_pht: a parametrised 1R1W synchronous RAM with write-read bypass.

Test Plan (defaults):
- Init: reset 1 cycle, then idle -> bp_ready rises exactly 4096 cycles after reset deassert. Every lookup then gives p_dir=0 and meta ctr=01.
- Training: PC=0x100, GHR=0; two updates with exe_dir=1 using the returned meta -> ctr 01->10->11; the next lookup gives p_dir=1 and ctr=11. A third taken update keeps ctr at 11.
- Speculation: 3 fetch_is_cond with p_dir 1,0,1 -> ghr_spec=0x005. Stall asserted during a 4th -> GHR stays 0x005 and outputs hold.
- Recovery: exe_miss with meta ghr_snap=0x0A3 and exe_dir=0 -> ghr_spec=0x146. A same-cycle fetch_is_cond is ignored.
- Bypass: update index 0x2F0 to ctr 10, with a lookup hitting 0x2F0 in the write cycle -> response ctr=10.
- Mid-sweep reset: assert reset at init_idx=1000 -> sweep restarts at 0; bp_ready rises 4096 cycles later.
